// File: rtl/tankwar_pkg.sv
// Shared definitions for the player input path.
// Bit indices of the packed button vectors {fire,right,left,down,up}, the
// resolved-direction encoding, and helpers that map between the two.
package tankwar_pkg;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_FIRE  = 4;

  typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  // Highest-priority held direction: up > down > left > right.
  function automatic dir_t prio_dir(input logic [3:0] held);
    if (held[BTN_UP])         return DIR_UP;
    else if (held[BTN_DOWN])  return DIR_DOWN;
    else if (held[BTN_LEFT])  return DIR_LEFT;
    else if (held[BTN_RIGHT]) return DIR_RIGHT;
    else                      return DIR_NONE;
  endfunction

  function automatic logic [3:0] dir_onehot(input dir_t d);
    logic [3:0] oh;
    oh = 4'b0;
    case (d)
      DIR_UP:    oh[BTN_UP]    = 1'b1;
      DIR_DOWN:  oh[BTN_DOWN]  = 1'b1;
      DIR_LEFT:  oh[BTN_LEFT]  = 1'b1;
      DIR_RIGHT: oh[BTN_RIGHT] = 1'b1;
      default:   oh = 4'b0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/player_input_conditioner_debouncer.sv
// button_debouncer: one asynchronous raw button bit in, one debounced level out.
//   clk, clrn : clock, synchronous active-low reset
//   btn_i     : raw asynchronous button
//   level_o   : debounced level; changes only after DEBOUNCE_CYCLES
//               consecutive cycles of disagreement with the current level
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic clrn,
  input  logic btn_i,
  output logic level_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

  always_comb begin
    cnt_inc  = cnt_q + CW'(1);
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_inc == CW'(DEBOUNCE_CYCLES)) stable_d = sync2_q;
      else                                 cnt_d    = cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level_o = stable_q;

endmodule

// File: rtl/player_input_conditioner.sv
// player_input_conditioner: board buttons -> game_engine control inputs.
//   clk, clrn   : clock, synchronous active-low reset
//   frame_tick  : one-cycle pulse per video frame (drives fire cooldown)
//   game_on     : gates the conditioned outputs and fire edges
//   btn_p*_i    : raw buttons {fire,right,left,down,up}
//   p*_ctrl_o   : registered {fire pulse, one-hot direction}
module player_input_conditioner
  import tankwar_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int FIRE_COOLDOWN   = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       frame_tick,
  input  logic       game_on,
  input  logic [4:0] btn_p1_i,
  input  logic [4:0] btn_p2_i,
  output logic [4:0] p1_ctrl_o,
  output logic [4:0] p2_ctrl_o
);

  localparam int NUM_PLAYERS = 2;
  localparam int NUM_BTNS    = 5;
  // Keep the cooldown counter at least one bit wide when the limit is disabled.
  localparam int CD_W = (FIRE_COOLDOWN < 1) ? 1 : $clog2(FIRE_COOLDOWN + 1);

  logic [NUM_PLAYERS-1:0][NUM_BTNS-1:0] btn_raw, btn_db, ctrl;

  assign btn_raw = {btn_p2_i, btn_p1_i};

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    for (genvar b = 0; b < NUM_BTNS; b++) begin : g_btn
      button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk     (clk),
        .clrn    (clrn),
        .btn_i   (btn_raw[p][b]),
        .level_o (btn_db[p][b])
      );
    end

    dir_t            act_q, act_d;
    logic [3:0]      dir_q, dir_d;
    logic            fire_prev_q, pulse_q, pulse_d;
    logic [CD_W-1:0] cd_q, cd_d;

    always_comb begin
      // The active direction holds until released; other presses only
      // matter as fallback, and from idle the priority order picks one.
      act_d = act_q;
      if ((dir_onehot(act_q) & btn_db[p][3:0]) == 4'b0)
        act_d = prio_dir(btn_db[p][3:0]);
      dir_d = game_on ? dir_onehot(act_d) : 4'b0;

      // Edge-only: a fire held while gated or cooling down never fires later.
      pulse_d = game_on && btn_db[p][BTN_FIRE] && !fire_prev_q && (cd_q == '0);
      cd_d    = cd_q;
      if (pulse_d)                         cd_d = CD_W'(FIRE_COOLDOWN);
      else if (frame_tick && cd_q != '0)   cd_d = cd_q - CD_W'(1);
    end

    always_ff @(posedge clk) begin
      if (!clrn) begin
        act_q       <= DIR_NONE;
        dir_q       <= 4'b0;
        fire_prev_q <= 1'b0;
        pulse_q     <= 1'b0;
        cd_q        <= '0;
      end else begin
        act_q       <= act_d;
        dir_q       <= dir_d;
        fire_prev_q <= btn_db[p][BTN_FIRE];
        pulse_q     <= pulse_d;
        cd_q        <= cd_d;
      end
    end

    assign ctrl[p] = {pulse_q, dir_q};
  end

  assign p1_ctrl_o = ctrl[0];
  assign p2_ctrl_o = ctrl[1];

endmodule

// File: tb/tb_player_input_conditioner.sv
module tb_player_input_conditioner;

  localparam int DB = 4;
  localparam int FC = 2;

  logic             clk = 1'b0;
  logic             clrn, frame_tick, game_on;
  logic [1:0][4:0]  raw;
  logic [4:0]       p1_ctrl_o, p2_ctrl_o;

  int vectors = 0, errs = 0;
  int pulse1 = 0, pulse2 = 0;

  // Reference model state (per player, per button)
  int s1[2][5], s2[2][5], stab[2][5], streak[2][5];
  int act[2], fprev[2], cd[2], expo[2];

  player_input_conditioner #(.DEBOUNCE_CYCLES(DB), .FIRE_COOLDOWN(FC)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .frame_tick (frame_tick),
    .game_on    (game_on),
    .btn_p1_i   (raw[0]),
    .btn_p2_i   (raw[1]),
    .p1_ctrl_o  (p1_ctrl_o),
    .p2_ctrl_o  (p2_ctrl_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the specified behaviour, from pre-edge state and inputs.
  task automatic model_edge();
    for (int p = 0; p < 2; p++) begin
      if (!clrn) begin
        for (int b = 0; b < 5; b++) begin
          s1[p][b] = 0; s2[p][b] = 0; stab[p][b] = 0; streak[p][b] = 0;
        end
        act[p] = -1; fprev[p] = 0; cd[p] = 0; expo[p] = 0;
      end else begin
        int dir, pulse;
        logic held;
        held = 1'b0;
        if (act[p] >= 0) held = (stab[p][act[p]] != 0);
        if (!held) begin
          act[p] = -1;
          for (int b = 0; b < 4; b++)
            if (act[p] < 0 && stab[p][b] != 0) act[p] = b;
        end
        dir = (game_on && act[p] >= 0) ? (1 << act[p]) : 0;
        pulse = (game_on && stab[p][4] != 0 && fprev[p] == 0 && cd[p] == 0) ? 1 : 0;
        if (pulse != 0)                 cd[p] = FC;
        else if (frame_tick && cd[p] > 0) cd[p] = cd[p] - 1;
        fprev[p] = stab[p][4];
        expo[p]  = (pulse << 4) | dir;
        // Level accepted after DB consecutive disagreeing synced samples.
        for (int b = 0; b < 5; b++) begin
          if (s2[p][b] != stab[p][b]) begin
            streak[p][b]++;
            if (streak[p][b] == DB) begin
              stab[p][b] = s2[p][b];
              streak[p][b] = 0;
            end
          end else streak[p][b] = 0;
          s2[p][b] = s1[p][b];
          s1[p][b] = int'(raw[p][b]);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("p1_ctrl", int'(p1_ctrl_o), expo[0]);
    chk("p2_ctrl", int'(p2_ctrl_o), expo[1]);
    if (p1_ctrl_o[4]) pulse1++;
    if (p2_ctrl_o[4]) pulse2++;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  // Release everything and let cooldowns run out.
  task automatic settle();
    raw = '0;
    for (int i = 0; i < 12; i++) begin
      frame_tick = (i % 2 == 0);
      step();
    end
    frame_tick = 1'b0;
  endtask

  initial begin
    int n;
    logic seen;
    clrn = 1'b0; frame_tick = 1'b0; game_on = 1'b1; raw = '1;

    // Reset with all buttons held
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_p1", int'(p1_ctrl_o), 0);
      chk("rst_p2", int'(p2_ctrl_o), 0);
    end
    clrn = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      step(); n++;
      seen = p1_ctrl_o[0];
    end
    chk("rst_up_seen", int'(seen), 1);
    chk("rst_up_not_early", int'(n >= 7), 1);

    // Bounce on p1 up, then held
    settle();
    for (int i = 0; i < 20; i++) begin
      raw[0][0] = ((i / 2) % 2 == 0);
      step();
      chk("bounce_quiet", int'(p1_ctrl_o), 0);
    end
    raw[0][0] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("bounce_wait", int'(p1_ctrl_o), 0);
    end
    step();
    chk("bounce_up_at7", int'(p1_ctrl_o), 5'b00001);

    // Direction resolve
    settle();
    raw[0][0] = 1'b1; repeat (10) step();
    raw[0][3] = 1'b1; repeat (10) step();
    chk("dir_up_kept", int'(p1_ctrl_o), 5'b00001);
    raw[0][0] = 1'b0; repeat (10) step();
    chk("dir_fallback_right", int'(p1_ctrl_o), 5'b01000);
    raw[0] = '0; repeat (10) step();
    raw[0][1] = 1'b1; raw[0][2] = 1'b1; repeat (10) step();
    chk("dir_prio_down", int'(p1_ctrl_o), 5'b00010);

    // Fire cooldown
    settle();
    pulse1 = 0;
    raw[0][4] = 1'b1; repeat (10) step();
    raw[0][4] = 1'b0; repeat (10) step();
    chk("cd_first", pulse1, 1);
    tick();
    pulse1 = 0;
    raw[0][4] = 1'b1; repeat (10) step();
    raw[0][4] = 1'b0; repeat (10) step();
    chk("cd_dropped", pulse1, 0);
    tick();
    pulse1 = 0;
    raw[0][4] = 1'b1; repeat (10) step();
    raw[0][4] = 1'b0; repeat (10) step();
    chk("cd_third", pulse1, 1);
    tick(); tick();
    pulse1 = 0;
    raw[0][4] = 1'b1;
    for (int f = 0; f < 5; f++) begin
      repeat (6) step();
      tick();
    end
    chk("hold_single", pulse1, 1);

    // game_on gating
    settle();
    game_on = 1'b0;
    raw[1][2] = 1'b1; raw[1][4] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("gate_p2_off", int'(p2_ctrl_o), 0);
    end
    pulse2 = 0;
    game_on = 1'b1;
    step();
    chk("gate_on_left", int'(p2_ctrl_o), 5'b00100);
    repeat (10) step();
    chk("gate_no_fire", pulse2, 0);

    // Reset mid-cooldown
    settle();
    pulse1 = 0;
    raw[0][4] = 1'b1; repeat (10) step();
    chk("rstcd_pulse", pulse1, 1);
    raw[0][4] = 1'b0;
    clrn = 1'b0; step(); clrn = 1'b1;
    repeat (3) step();
    pulse1 = 0;
    raw[0][4] = 1'b1; repeat (10) step();
    chk("rstcd_repulse", pulse1, 1);

    // Randomized traffic against the model
    settle();
    for (int i = 0; i < 4000; i++) begin
      for (int p = 0; p < 2; p++)
        for (int b = 0; b < 5; b++)
          if ($urandom_range(11) == 0) raw[p][b] = ~raw[p][b];
      frame_tick = ($urandom_range(4) == 0);
      if ($urandom_range(59) == 0) game_on = ~game_on;
      clrn = ($urandom_range(299) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
